// File: rtl/playfield_pkg.sv
// Shared types and constants for the playfield store and the colour mapper.
// SCORE_TABLE/score_for are used only when PLAYFIELD_SCORE_EN is defined.
package playfield_pkg;

    localparam int DEF_COLS    = 10;
    localparam int DEF_ROWS    = 20;
    localparam int DEF_COLOR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [23:0] SCORE_TABLE [5] = '{24'd0, 24'd40, 24'd100, 24'd300, 24'd1200};

    function automatic logic [23:0] score_for(input int unsigned lines);
        if (lines > 32'd4) begin
            return SCORE_TABLE[4];
        end else begin
            return SCORE_TABLE[lines];
        end
    endfunction

endpackage

// File: rtl/playfield_grid_row_full_detect.sv
// Combinational full-row detector: high when every cell of the row is non-zero.
module row_full_detect #(
    parameter int COLS    = 10,
    parameter int COLOR_W = 3
) (
    input  logic [COLS-1:0][COLOR_W-1:0] row,
    output logic                         full
);

    // AND-reduce the per-cell occupancy bits.
    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            full = full & (|row[c]);
        end
    end

endmodule

// File: rtl/playfield_grid.sv
// Cell-resolution Tetris playfield: piece lock, full-row detection and collapse.
// Define PLAYFIELD_SCORE_EN to add a saturating 24-bit score output.
module playfield_grid
    import playfield_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int NUM_SQ  = 4,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int COL_W   = $clog2(COLS),
    parameter int ROW_W   = $clog2(ROWS)
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               clear,
    input  logic                               lock,
    input  logic [NUM_SQ-1:0][COL_W-1:0]       piece_col,
    input  logic [NUM_SQ-1:0][ROW_W-1:0]       piece_row,
    input  logic [COLOR_W-1:0]                 piece_color,
    input  logic [COL_W-1:0]                   rd_col,
    input  logic [ROW_W-1:0]                   rd_row,
    output logic [COLOR_W-1:0]                 rd_color,
    output logic                               busy,
    output logic                               lines_done,
    output logic [$clog2(NUM_SQ+1)-1:0]        lines_cnt,
    output logic [15:0]                        total_lines,
`ifdef PLAYFIELD_SCORE_EN
    output logic [23:0]                        score,
`endif
    output logic                               game_over,
    output logic                               oob_err
);

    localparam int CNT_W = $clog2(NUM_SQ + 1);

    state_t                          state_r, state_nxt_s;
    logic [ROW_W-1:0]                ptr_r;
    logic [CNT_W-1:0]                cnt_r, cnt_nxt_s, lines_cnt_r;
    logic [NUM_SQ-1:0][COL_W-1:0]    pcol_r;
    logic [NUM_SQ-1:0][ROW_W-1:0]    prow_r;
    logic [COLOR_W-1:0]              pcolor_r, rd_color_r;
    logic [COLOR_W-1:0]              grid_r [ROWS][COLS];
    logic [COLS-1:0][COLOR_W-1:0]    scan_row_s, above_row_s;
    logic                            row_full_s, above_full_s;
    logic [NUM_SQ-1:0]               in_range_s;
    logic                            oob_any_s, hit_s, rd_ok_s, ptr_dec_s;
    logic                            accept_s, wipe_s;
    logic                            busy_r, lines_done_r, game_over_r, oob_r;
    logic [15:0]                     total_r, total_nxt_s;
    logic [16:0]                     total_sum_s;
`ifdef PLAYFIELD_SCORE_EN
    logic [23:0]                     score_r, score_nxt_s;
    logic [24:0]                     score_sum_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && lock && !clear;
    assign wipe_s   = (state_r == ST_IDLE) && clear;

    // Per-cell range check plus overlap / top-row detection for the latched piece.
    always_comb begin
        in_range_s = '0;
        oob_any_s  = 1'b0;
        hit_s      = 1'b0;
        for (int i = 0; i < NUM_SQ; i++) begin
            in_range_s[i] = ({1'b0, pcol_r[i]} < (COL_W+1)'(COLS)) &&
                            ({1'b0, prow_r[i]} < (ROW_W+1)'(ROWS));
            if (in_range_s[i]) begin
                hit_s = hit_s | (grid_r[prow_r[i]][pcol_r[i]] != '0) | (prow_r[i] == '0);
            end else begin
                oob_any_s = 1'b1;
            end
        end
    end

    // Row selection for the detectors, read-address check, counters and saturating sums.
    always_comb begin
        scan_row_s  = '0;
        above_row_s = '0;
        for (int c = 0; c < COLS; c++) begin
            scan_row_s[c] = grid_r[ptr_r][c];
            if (ptr_r != '0) begin
                above_row_s[c] = grid_r[ptr_r - 1'b1][c];
            end else begin
                above_row_s[c] = '0;
            end
        end
        rd_ok_s = ({1'b0, rd_col} < (COL_W+1)'(COLS)) && ({1'b0, rd_row} < (ROW_W+1)'(ROWS));
        case (state_r)
            ST_LOCK:  cnt_nxt_s = '0;
            ST_SHIFT: cnt_nxt_s = cnt_r + 1'b1;
            default:  cnt_nxt_s = cnt_r;
        endcase
        ptr_dec_s = (ptr_r != '0) &&
                    (((state_r == ST_SCAN) && !row_full_s) || ((state_r == ST_SHIFT) && !above_full_s));
        total_sum_s = {1'b0, total_r} + 17'(cnt_nxt_s);
        total_nxt_s = total_sum_s[16] ? 16'hFFFF : total_sum_s[15:0];
`ifdef PLAYFIELD_SCORE_EN
        score_sum_s = {1'b0, score_r} + {1'b0, score_for(int'(cnt_nxt_s))};
        score_nxt_s = score_sum_s[24] ? 24'hFFFFFF : score_sum_s[23:0];
`endif
    end

    row_full_detect #(.COLS(COLS), .COLOR_W(COLOR_W)) u_scan_full (
        .row  (scan_row_s),
        .full (row_full_s)
    );

    // The row dropping into ptr is checked during the shift itself, so each cleared row costs one cycle.
    row_full_detect #(.COLS(COLS), .COLOR_W(COLOR_W)) u_above_full (
        .row  (above_row_s),
        .full (above_full_s)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = accept_s ? ST_LOCK : ST_IDLE;
            ST_LOCK:  state_nxt_s = ST_SCAN;
            ST_SCAN: begin
                if (row_full_s) begin
                    state_nxt_s = ST_SHIFT;
                end else if (ptr_r == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_SHIFT: begin
                if (ptr_r == '0) begin
                    state_nxt_s = ST_DONE;
                end else if (above_full_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Scan pointer, line counter, latched piece, sticky flags and status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_r        <= '0;
            cnt_r        <= '0;
            pcol_r       <= '0;
            prow_r       <= '0;
            pcolor_r     <= '0;
            busy_r       <= 1'b0;
            lines_done_r <= 1'b0;
            lines_cnt_r  <= '0;
            total_r      <= 16'd0;
            game_over_r  <= 1'b0;
            oob_r        <= 1'b0;
`ifdef PLAYFIELD_SCORE_EN
            score_r      <= 24'd0;
`endif
        end else begin
            busy_r       <= (state_nxt_s != ST_IDLE);
            lines_done_r <= (state_nxt_s == ST_DONE);
            cnt_r        <= cnt_nxt_s;
            if (accept_s) begin
                pcol_r   <= piece_col;
                prow_r   <= piece_row;
                pcolor_r <= piece_color;
            end
            if (wipe_s) begin
                game_over_r <= 1'b0;
                oob_r       <= 1'b0;
`ifdef PLAYFIELD_SCORE_EN
                score_r     <= 24'd0;
`endif
            end
            if (state_r == ST_LOCK) begin
                ptr_r <= ROW_W'(ROWS - 1);
                if (hit_s)     game_over_r <= 1'b1;
                if (oob_any_s) oob_r       <= 1'b1;
            end
            if (ptr_dec_s) begin
                ptr_r <= ptr_r - 1'b1;
            end
            if (state_nxt_s == ST_DONE) begin
                lines_cnt_r <= cnt_nxt_s;
                total_r     <= total_nxt_s;
`ifdef PLAYFIELD_SCORE_EN
                score_r     <= score_nxt_s;
`endif
            end
        end
    end

    // Grid storage: wipe, piece write and parallel collapse of rows 0..ptr.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    grid_r[r][c] <= '0;
        end else if (wipe_s) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    grid_r[r][c] <= '0;
        end else if (state_r == ST_LOCK) begin
            for (int i = 0; i < NUM_SQ; i++)
                if (in_range_s[i]) grid_r[prow_r[i]][pcol_r[i]] <= pcolor_r;
        end else if (state_r == ST_SHIFT) begin
            for (int c = 0; c < COLS; c++) grid_r[0][c] <= '0;
            for (int r = 1; r < ROWS; r++)
                if (ROW_W'(r) <= ptr_r)
                    for (int c = 0; c < COLS; c++)
                        grid_r[r][c] <= grid_r[r-1][c];
        end
    end

    // Registered read port, live in every state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_color_r <= '0;
        end else begin
            rd_color_r <= rd_ok_s ? grid_r[rd_row][rd_col] : '0;
        end
    end

    assign rd_color    = rd_color_r;
    assign busy        = busy_r;
    assign lines_done  = lines_done_r;
    assign lines_cnt   = lines_cnt_r;
    assign total_lines = total_r;
    assign game_over   = game_over_r;
    assign oob_err     = oob_r;
`ifdef PLAYFIELD_SCORE_EN
    assign score       = score_r;
`endif

endmodule
